// File: rtl/shift_register_univ.sv
// Universal shift register: hold / shift / rotate / parallel load in either direction,
// with a saturating shift counter and a one-cycle pulse when a full word has moved.
module shift_register_univ #(
  parameter int unsigned     BIT     = 8,
  parameter logic [BIT-1:0]  RST_VAL = '0,
  localparam int unsigned    CW      = $clog2(BIT + 1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  input  logic [1:0]     i_mode,
  input  logic           i_dir,
  input  logic           i_serial,
  input  logic [BIT-1:0] i_parrel,
  output logic [BIT-1:0] o_parrel,
  output logic           o_serial,
  output logic [CW-1:0]  o_cnt,
  output logic           o_done
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_ROT   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  mode_e          mode;
  logic [BIT-1:0] q;
  logic [BIT-1:0] shr_q, shl_q, ror_q, rol_q;
  logic [CW-1:0]  cnt;
  logic           done;
  logic           cnt_last;
  logic           cnt_full;

  assign mode = mode_e'(i_mode);

  // A single-bit register has no neighbours: shift takes the fill bit, rotate holds.
  if (BIT == 1) begin : g_narrow
    always_comb begin
      shr_q = i_serial;
      shl_q = i_serial;
      ror_q = q;
      rol_q = q;
    end
  end else begin : g_wide
    always_comb begin
      shr_q = {i_serial, q[BIT-1:1]};
      shl_q = {q[BIT-2:0], i_serial};
      ror_q = {q[0], q[BIT-1:1]};
      rol_q = {q[BIT-2:0], q[BIT-1]};
    end
  end

  assign cnt_last = (cnt == CW'(BIT - 1));
  assign cnt_full = (cnt == CW'(BIT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q    <= RST_VAL;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (i_en) begin
        unique case (mode)
          MODE_HOLD: ;
          MODE_SHIFT, MODE_ROT: begin
            if (mode == MODE_SHIFT) q <= i_dir ? shl_q : shr_q;
            else                    q <= i_dir ? rol_q : ror_q;
            if (!cnt_full) cnt <= cnt + 1'b1;
            done <= cnt_last;
          end
          MODE_LOAD: begin
            q   <= i_parrel;
            cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_parrel = q;
  assign o_serial = i_dir ? q[BIT-1] : q[0];
  assign o_cnt    = cnt;
  assign o_done   = done;

endmodule
